// File: rtl/jtag_reg_bridge.sv
// BSCAN user-chain to register-access bridge, oversampling the JTAG pins on clk.
// Optional macro JTAG_REG_BRIDGE_READBACK_EN: capture returns control registers instead of stat_in.
module jtag_reg_bridge #(
    parameter int DATA_W      = 16,
    parameter int NUM_REGS    = 8,
    parameter int ADDR_W      = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         jtag_tck,
    input  logic                         jtag_tdi,
    input  logic                         jtag_sel,
    input  logic                         jtag_capture,
    input  logic                         jtag_shift,
    input  logic                         jtag_update,
    input  logic                         jtag_reset,
    output logic                         jtag_tdo,
    input  logic [NUM_REGS*DATA_W-1:0]   stat_in,
    output logic [NUM_REGS*DATA_W-1:0]   reg_out,
    output logic                         wr_stb,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         err
);

    localparam int DR_W  = 1 + ADDR_W + DATA_W;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] NUM_REGS_C = (ADDR_W + 1)'(NUM_REGS);

    localparam int S_TCK = 0;
    localparam int S_TDI = 1;
    localparam int S_SEL = 2;
    localparam int S_CAP = 3;
    localparam int S_SHF = 4;
    localparam int S_UPD = 5;
    localparam int S_RST = 6;

    logic [6:0]        w_jtag_in;
    logic [6:0]        r_sync [SYNC_STAGES];
    logic              w_tck_s, w_tdi_s, w_sel_s, w_cap_s, w_shf_s, w_upd_s, w_rst_s;
    logic              r_tck_prev, r_upd_prev;
    logic              w_tck_rise, w_update_rise;

    logic [DR_W-1:0]   r_sr;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W-1:0] r_wr_addr;
    logic              r_wr_stb;
    logic              r_err;
    logic              r_tdo;
    logic [DATA_W-1:0] r_regs [NUM_REGS];

    logic [ADDR_W-1:0] w_upd_addr;
    logic [ADDR_W-1:0] w_cap_addr;
    logic [DATA_W-1:0] w_upd_data;
    logic              w_upd_wr;
    logic              w_upd_in_range;
    logic              w_do_write;
    logic [DATA_W-1:0] w_rd_words [DEPTH];

    assign w_jtag_in = {jtag_reset, jtag_update, jtag_shift, jtag_capture,
                        jtag_sel, jtag_tdi, jtag_tck};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
        end else begin
            r_sync[0] <= w_jtag_in;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    assign w_tck_s = r_sync[SYNC_STAGES-1][S_TCK];
    assign w_tdi_s = r_sync[SYNC_STAGES-1][S_TDI];
    assign w_sel_s = r_sync[SYNC_STAGES-1][S_SEL];
    assign w_cap_s = r_sync[SYNC_STAGES-1][S_CAP];
    assign w_shf_s = r_sync[SYNC_STAGES-1][S_SHF];
    assign w_upd_s = r_sync[SYNC_STAGES-1][S_UPD];
    assign w_rst_s = r_sync[SYNC_STAGES-1][S_RST];

    assign w_tck_rise    = w_tck_s & ~r_tck_prev;
    assign w_update_rise = w_upd_s & ~r_upd_prev & w_sel_s;

    assign w_upd_addr     = r_sr[DATA_W +: ADDR_W];
    assign w_upd_data     = r_sr[DATA_W-1:0];
    assign w_upd_wr       = r_sr[DR_W-1];
    assign w_upd_in_range = ({1'b0, w_upd_addr} < NUM_REGS_C);
    assign w_do_write     = w_update_rise & ~w_rst_s & w_upd_wr & w_upd_in_range;
    // A capture coinciding with an update sees the freshly selected address.
    assign w_cap_addr     = w_update_rise ? w_upd_addr : r_rd_addr;

    // Read words padded to the full address space; unpopulated slots read as 0.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_rd_words
            if (gi < NUM_REGS) begin : g_pop
`ifdef JTAG_REG_BRIDGE_READBACK_EN
                assign w_rd_words[gi] = r_regs[gi];
`else
                assign w_rd_words[gi] = stat_in[gi*DATA_W +: DATA_W];
`endif
            end else begin : g_empty
                assign w_rd_words[gi] = '0;
            end
        end
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg_out
            assign reg_out[gi*DATA_W +: DATA_W] = r_regs[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_do_write && (w_upd_addr == ADDR_W'(i))) r_regs[i] <= w_upd_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sr       <= '0;
            r_rd_addr  <= '0;
            r_wr_addr  <= '0;
            r_wr_stb   <= 1'b0;
            r_err      <= 1'b0;
            r_tdo      <= 1'b0;
            r_tck_prev <= 1'b0;
            r_upd_prev <= 1'b0;
        end else begin
            r_tck_prev <= w_tck_s;
            r_upd_prev <= w_upd_s;
            r_tdo      <= r_sr[0];
            r_wr_stb   <= 1'b0;
            if (w_rst_s) begin
                r_sr      <= '0;
                r_rd_addr <= '0;
            end else begin
                if (w_update_rise) begin
                    r_rd_addr <= w_upd_addr;
                    if (!w_upd_in_range) begin
                        r_err <= 1'b1;
                    end else if (w_upd_wr) begin
                        r_wr_addr <= w_upd_addr;
                        r_wr_stb  <= 1'b1;
                    end
                end
                if (w_tck_rise && w_sel_s) begin
                    if (w_cap_s)
                        r_sr <= {1'b0, w_cap_addr, w_rd_words[w_cap_addr]};
                    else if (w_shf_s)
                        r_sr <= {w_tdi_s, r_sr[DR_W-1:1]};
                end
            end
        end
    end

    assign jtag_tdo = r_tdo;
    assign wr_stb   = r_wr_stb;
    assign wr_addr  = r_wr_addr;
    assign err      = r_err;

endmodule

// File: tb/tb_jtag_reg_bridge.sv
// Directed bench for jtag_reg_bridge: bit-banged BSCAN scans at TCK = clk/10.
module tb_jtag_reg_bridge;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 6;
    localparam int ADDR_W   = 3;
    localparam int W        = NUM_REGS * DATA_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              jtag_tck, jtag_tdi, jtag_sel, jtag_capture;
    logic              jtag_shift, jtag_update, jtag_reset;
    logic              jtag_tdo;
    logic [W-1:0]      stat_in;
    logic [W-1:0]      reg_out;
    logic              wr_stb;
    logic [ADDR_W-1:0] wr_addr;
    logic              err;

    int                checks = 0;
    int                errors = 0;
    int                stb_cnt = 0;
    logic [ADDR_W-1:0] last_wr_addr = '0;

    logic [19:0]       dout;
    logic [W-1:0]      exp_regs;
    logic [15:0]       exp_w0, exp_w1, exp_w2;

    jtag_reg_bridge #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .jtag_tck(jtag_tck), .jtag_tdi(jtag_tdi), .jtag_sel(jtag_sel),
        .jtag_capture(jtag_capture), .jtag_shift(jtag_shift),
        .jtag_update(jtag_update), .jtag_reset(jtag_reset),
        .jtag_tdo(jtag_tdo), .stat_in(stat_in), .reg_out(reg_out),
        .wr_stb(wr_stb), .wr_addr(wr_addr), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_stb === 1'b1) begin
            stb_cnt++;
            last_wr_addr = wr_addr;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tck_pulse();
        jtag_tck = 1'b0; clks(5);
        jtag_tck = 1'b1; clks(5);
    endtask

    // Optional capture, then 20 shift edges; TDO sampled just before each rising edge.
    task automatic scan(input logic [19:0] din, input bit do_cap, output logic [19:0] q);
        jtag_sel = 1'b1;
        if (do_cap) begin
            jtag_capture = 1'b1;
            tck_pulse();
            jtag_capture = 1'b0;
        end
        jtag_shift = 1'b1;
        for (int i = 0; i < 20; i++) begin
            jtag_tdi = din[i];
            jtag_tck = 1'b0; clks(5);
            q[i] = jtag_tdo;
            jtag_tck = 1'b1; clks(5);
        end
        jtag_shift = 1'b0;
        jtag_tck   = 1'b0; clks(5);
        $display("scan din=%05h cap=%0d tdo=%05h", din, do_cap, q);
    endtask

    task automatic do_update();
        jtag_update = 1'b1; clks(6);
        jtag_update = 1'b0; clks(6);
        $display("update wr_stb_count=%0d wr_addr=%0d err=%0b", stb_cnt, last_wr_addr, err);
    endtask

    initial begin
        rst_n = 1'b0;
        jtag_tck = 1'b0; jtag_tdi = 1'b0; jtag_sel = 1'b0; jtag_capture = 1'b0;
        jtag_shift = 1'b0; jtag_update = 1'b0; jtag_reset = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) stat_in[i*DATA_W +: DATA_W] = 16'hC0D0 + 16'(i);
        stat_in[2*DATA_W +: DATA_W] = 16'h1234;
`ifdef JTAG_REG_BRIDGE_READBACK_EN
        exp_w0 = 16'h0000; exp_w1 = 16'hBEEF; exp_w2 = 16'h0000;
`else
        exp_w0 = 16'hC0D0; exp_w1 = 16'hC0D1; exp_w2 = 16'h1234;
`endif
        clks(5);
        rst_n = 1'b1;
        clks(20);

        // Reset and idle
        check("rst_reg_out", reg_out, '0);
        check("rst_err", err, 1'b0);
        check("rst_tdo", jtag_tdo, 1'b0);
        check("rst_wr_stb", wr_stb, 1'b0);
        check("rst_stb_cnt", stb_cnt, 0);

        // Write 0xA5C3 to register 5
        scan({1'b1, 3'd5, 16'hA5C3}, 1'b0, dout);
        do_update();
        exp_regs = '0;
        exp_regs[5*DATA_W +: DATA_W] = 16'hA5C3;
        check("wr5_stb_cnt", stb_cnt, 1);
        check("wr5_wr_addr", last_wr_addr, 3'd5);
        check("wr5_reg_out", reg_out, exp_regs);
        check("wr5_err", err, 1'b0);

        // Select register 2 for read, then capture and shift it out
        scan({1'b0, 3'd2, 16'h0000}, 1'b0, dout);
        do_update();
        scan(20'h0, 1'b1, dout);
        check("rd2_tdo", dout, {1'b0, 3'd2, exp_w2});
        check("rd2_stb_cnt", stb_cnt, 1);
        check("rd2_reg_out", reg_out, exp_regs);

        // Out-of-range write to 7: no write, sticky err, capture returns zero data
        scan({1'b1, 3'd7, 16'hFFFF}, 1'b0, dout);
        do_update();
        check("oor7_err", err, 1'b1);
        check("oor7_stb_cnt", stb_cnt, 1);
        check("oor7_reg_out", reg_out, exp_regs);
        scan(20'h0, 1'b1, dout);
        check("oor7_tdo", dout, {1'b0, 3'd7, 16'h0000});
        scan({1'b1, 3'd6, 16'h5555}, 1'b0, dout);
        do_update();
        check("oor6_stb_cnt", stb_cnt, 1);
        check("oor6_reg_out", reg_out, exp_regs);
        check("oor6_err", err, 1'b1);

        // jtag_reset mid-shift clears sr and rd_addr only
        scan({1'b0, 3'd3, 16'h0000}, 1'b0, dout);
        do_update();
        jtag_sel = 1'b1; jtag_shift = 1'b1; jtag_tdi = 1'b1;
        for (int i = 0; i < 7; i++) tck_pulse();
        jtag_reset = 1'b1; clks(6);
        jtag_reset = 1'b0; jtag_shift = 1'b0; clks(6);
        check("jrst_tdo", jtag_tdo, 1'b0);
        scan(20'h0, 1'b1, dout);
        check("jrst_tdo_capture", dout, {1'b0, 3'd0, exp_w0});
        check("jrst_reg_out", reg_out, exp_regs);
        check("jrst_err", err, 1'b1);

        // Write 0xBEEF to register 1, select it and capture
        scan({1'b1, 3'd1, 16'hBEEF}, 1'b0, dout);
        do_update();
        exp_regs[1*DATA_W +: DATA_W] = 16'hBEEF;
        check("wr1_stb_cnt", stb_cnt, 2);
        check("wr1_wr_addr", last_wr_addr, 3'd1);
        check("wr1_reg_out", reg_out, exp_regs);
        scan({1'b0, 3'd1, 16'h0000}, 1'b0, dout);
        do_update();
        scan(20'h0, 1'b1, dout);
        check("rd1_tdo", dout, {1'b0, 3'd1, exp_w1});
        check("rd1_stb_cnt", stb_cnt, 2);

        // rst_n mid-shift aborts the scan and clears state
        jtag_sel = 1'b1; jtag_shift = 1'b1; jtag_tdi = 1'b1;
        for (int i = 0; i < 5; i++) tck_pulse();
        jtag_shift = 1'b0; jtag_tck = 1'b0;
        rst_n = 1'b0; clks(3);
        check("rstn_reg_out", reg_out, '0);
        check("rstn_err", err, 1'b0);
        check("rstn_tdo", jtag_tdo, 1'b0);
        check("rstn_wr_addr", wr_addr, 3'd0);
        rst_n = 1'b1; clks(6);
`ifdef JTAG_REG_BRIDGE_READBACK_EN
        exp_w0 = 16'h0000;
`endif
        scan(20'h0, 1'b1, dout);
        check("rstn_tdo_capture", dout, {1'b0, 3'd0, exp_w0});
        check("rstn_stb_cnt", stb_cnt, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
